param_mem_reader: RTL
=====================

Name: param_mem_reader

Overview:
- Read-side sequencer for the 16-entry x 16-bit parameter memory that the host loads through the memory's write port.
- On a start pulse, reads words 0..scan_len-1 through the memory's shared address path and presents each word downstream on a valid/ready stream (RHD command sequencer).
- The memory is single-port: a host write (RAM_we=1) steals the address bus that cycle. The reader detects this collision and retries the read.

Parameters:
- DEPTH, 16, number of parameter words; power of two.
- ADDR_W, 4, internal index width, log2(DEPTH).
- RAM_ADDR_W, 10, width of the memory read-address port.
- DATA_W, 16, parameter word width.

Ports:
- clk_A  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a scan when idle.
- abort  input  1  synchronous; cancels a scan in progress.
- scan_len  input  ADDR_W+1  number of words to read; sampled on start.
- RAM_addr_B  output  RAM_ADDR_W  read address to the memory.
- RAM_we  input  1  monitored host write enable (same net the memory sees).
- RAM_data_out_B  input  DATA_W  memory read data; registered, 1-cycle latency.
- cmd_valid  output  1  cmd_data/cmd_index valid.
- cmd_ready  input  1  downstream accepts the word.
- cmd_data  output  DATA_W  parameter word.
- cmd_index  output  ADDR_W  address the word was read from.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.
- collision_cnt  output  8  saturating count of read retries since reset.

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE. RAM_addr_B, cmd_valid, cmd_data, cmd_index, busy, done and collision_cnt all 0. Applies mid-scan with no done pulse.
- RAM_addr_B[RAM_ADDR_W-1:ADDR_W] is always 0. The low bits equal the current index.
- States: IDLE, ADDR, CAPT, PRESENT, DONE.
- IDLE:
  - start=1 and scan_len=0: go to DONE; no words issued.
  - start=1 and scan_len>0: latch len=min(scan_len,DEPTH), index=0, go to ADDR.
  - start is ignored in every state other than IDLE.
- ADDR: drive RAM_addr_B=index.
  - RAM_we=1 this cycle (collision): stay in ADDR and increment collision_cnt, saturating at 255.
  - Otherwise: go to CAPT.
- CAPT: RAM_data_out_B holds the word for index. Register it into cmd_data, set cmd_index=index, go to PRESENT.
  - A RAM_we in CAPT does not corrupt the capture; the output register was loaded at the previous edge.
- PRESENT: cmd_valid=1. cmd_data and cmd_index are held stable until cmd_valid & cmd_ready.
  - On handshake with index=len-1: go to DONE.
  - On handshake otherwise: index+1, go to ADDR.
  - cmd_valid drops for at least ADDR+CAPT (2 cycles) between words.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start at edge 0 puts the FSM in ADDR in cycle 1 and CAPT in cycle 2; cmd_valid=1 from cycle 3. With cmd_ready held 1 and no collisions, the throughput is one word per 3 cycles.
- abort=1 in any state: IDLE at the next edge, cmd_valid=0, no done pulse. abort has priority over start, handshake and collision.
- scan_len>DEPTH: clamped to DEPTH. Index never wraps past DEPTH-1.
- The reader never asserts a write. Words are read as stored at the ADDR cycle; a host write to an already-read address does not re-issue that word.

Decomposition:
- Shared package param_mem_pkg holds:
  - the state enum (IDLE, ADDR, CAPT, PRESENT, DONE);
  - the constants PARAM_DEPTH=16, PARAM_ADDR_W=4 and PARAM_DATA_W=16, so the memory wrapper and the host writer use the same values.
- Single flat module; no sub-module. The saturating counter is inline.

Test Plan:
- Preload mem[0..3]=16'hA000..16'hA003; scan_len=4; cmd_ready=1 → cmd_valid first at cycle 3 after start. cmd_data sequence A000, A001, A002, A003 with cmd_index 0..3; done pulses once, 1 cycle after the 4th handshake; collision_cnt=0.
- Same setup, with RAM_we=1 (write addr 9) during the ADDR cycle of index 2 for 3 consecutive cycles → index 2 is read after the write ends; data is still A002; collision_cnt=3; cmd_data sequence is unchanged.
- cmd_ready=0 for 10 cycles while word 1 is presented → cmd_valid stays 1; cmd_data=A001 and cmd_index=1 are stable; the RAM address is not advanced.
- scan_len=0 → done pulses at cycle 1; cmd_valid is never asserted. scan_len=20 → exactly 16 words (indices 0..15) are issued.
- abort asserted while in PRESENT at index 1 → IDLE next cycle, cmd_valid=0, busy=0, no done. A following start rescans from index 0.
- reset_n=0 mid-scan, then start is pulsed (with scan_len=4) while busy and again after release → all outputs 0 after reset; the start pulsed during busy is ignored; the next start performs a full scan.

Source files
------------

// File: rtl/param_mem_pkg.sv
// ---------------------------------------------------------------------------
// param_mem_pkg
//
// Shared definitions for the parameter memory subsystem. The memory wrapper,
// the host-side writer and the read sequencer all size themselves from these
// constants so that the depth and word width stay consistent everywhere.
//
// Contents:
//    PARAM_DEPTH      number of parameter words held in the memory
//    PARAM_ADDR_W     index width needed to address PARAM_DEPTH words
//    PARAM_DATA_W     width of one parameter word
//    PARAM_RAM_ADDR_W width of the memory's physical address port
//    reader_state_t   states of the read sequencer
// ---------------------------------------------------------------------------
package param_mem_pkg;

   localparam int PARAM_DEPTH      = 16;
   localparam int PARAM_ADDR_W     = 4;
   localparam int PARAM_DATA_W     = 16;
   localparam int PARAM_RAM_ADDR_W = 10;

   // Read sequencer states. ADDR drives the address and CAPT waits out the
   // memory's registered read latency before the word is presented.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      CAPT    = 3'd2,
      PRESENT = 3'd3,
      DONE    = 3'd4
   } reader_state_t;

endpackage

// File: rtl/param_mem_reader.sv
// ---------------------------------------------------------------------------
// param_mem_reader
//
// Read-side sequencer for the single-port parameter memory. A start pulse
// walks addresses 0..len-1 and hands each stored word to the downstream
// command sequencer over a valid/ready stream. Because the memory has a
// single address path, any host write (RAM_we) during the address cycle
// steals the bus; the read is then retried and the retry is counted.
//
// Ports:
//    clk_A           system clock, rising edge
//    reset_n         synchronous active-low reset
//    start           one-cycle pulse, begins a scan from IDLE
//    abort           cancels any scan, returns to IDLE next edge
//    scan_len        number of words to read (clamped to DEPTH)
//    RAM_addr_B      read address to the memory (upper bits always 0)
//    RAM_we          host write enable, monitored for bus collisions
//    RAM_data_out_B  registered memory read data, one-cycle latency
//    cmd_valid       cmd_data / cmd_index are valid
//    cmd_ready       downstream accepts the presented word
//    cmd_data        parameter word
//    cmd_index       address the word was read from
//    busy            high whenever the sequencer is not IDLE
//    done            one-cycle pulse after the last word is accepted
//    collision_cnt   saturating count of read retries since reset
// ---------------------------------------------------------------------------
module param_mem_reader
   import param_mem_pkg::*;
#(
   parameter int DEPTH      = PARAM_DEPTH,
   parameter int ADDR_W     = PARAM_ADDR_W,
   parameter int RAM_ADDR_W = PARAM_RAM_ADDR_W,
   parameter int DATA_W     = PARAM_DATA_W
) (
   input  logic                  clk_A,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_W:0]       scan_len,
   output logic [RAM_ADDR_W-1:0] RAM_addr_B,
   input  logic                  RAM_we,
   input  logic [DATA_W-1:0]     RAM_data_out_B,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [DATA_W-1:0]     cmd_data,
   output logic [ADDR_W-1:0]     cmd_index,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            collision_cnt
);

   reader_state_t     state;
   reader_state_t     state_next;

   logic [ADDR_W-1:0] index;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   len_clamped;
   logic              last_word;

   // Requests longer than the memory are trimmed to the full depth so the
   // index never has to wrap; the last word is the one at len-1.
   assign len_clamped = (scan_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : scan_len;
   assign last_word   = ({1'b0, index} == (len - (ADDR_W+1)'(1)));

   // The physical address port is wider than the parameter space; the
   // upper bits stay at zero so the reader only ever touches the
   // parameter region.
   assign RAM_addr_B = RAM_ADDR_W'(index);

   // State register. Reset is synchronous and drops any scan in flight
   // without producing a done pulse, since DONE is the only state that
   // raises it.
   always_ff @(posedge clk_A) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Abort overrides everything else, including a
   // pending handshake or a collision. A zero-length request goes straight
   // to DONE so the requester still sees completion. A host write during
   // ADDR means the memory served the host instead of us, so the address
   // cycle repeats until the bus is free.
   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_next = (scan_len == '0) ? DONE : ADDR;
               end
            end
            ADDR: begin
               if (!RAM_we) begin
                  state_next = CAPT;
               end
            end
            CAPT: begin
               state_next = PRESENT;
            end
            PRESENT: begin
               if (cmd_ready) begin
                  state_next = last_word ? DONE : ADDR;
               end
            end
            DONE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Datapath registers. The scan length is latched at start so that the
   // scan_len input may change freely during the scan. In CAPT the memory
   // output register already holds the word addressed during ADDR, so a
   // host write in CAPT cannot disturb it. The presented word is held in
   // cmd_data/cmd_index until the downstream accepts it, and the index
   // only advances on a handshake that is not the final word.
   always_ff @(posedge clk_A) begin
      if (!reset_n) begin
         index         <= '0;
         len           <= '0;
         cmd_data      <= '0;
         cmd_index     <= '0;
         collision_cnt <= '0;
      end else if (!abort) begin
         case (state)
            IDLE: begin
               if (start) begin
                  index <= '0;
                  len   <= len_clamped;
               end
            end
            ADDR: begin
               if (RAM_we && (collision_cnt != 8'hFF)) begin
                  collision_cnt <= collision_cnt + 8'd1;
               end
            end
            CAPT: begin
               cmd_data  <= RAM_data_out_B;
               cmd_index <= index;
            end
            PRESENT: begin
               if (cmd_ready && !last_word) begin
                  index <= index + ADDR_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Moore outputs decoded straight from the state register, so they are
   // glitch-free relative to the clock and drop together on reset or abort.
   always_comb begin
      cmd_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
         end
         PRESENT: begin
            cmd_valid = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
